// File: rtl/tick_counter_pkg.sv
// tick_counter_pkg: shared types and constants for the tick_counter slice.
//   state_t  - control FSM states
//   bcd_t    - one BCD decade
//   BCD_MAX / BCD_MIN - decade limits used for wrap, carry and borrow
package tick_counter_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

endpackage

// File: rtl/tick_counter_if.sv
// tick_counter_if: enable/control inputs and count/status outputs of tick_counter.
//   master: drives enable_i, run_i, up_i, clear_i; observes count_o, tick_o, wrap_o, stall_o
//   slave : the counter side of the same signals
interface tick_counter_if
  import tick_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
);

  logic                    enable_i;
  logic                    run_i;
  logic                    up_i;
  logic                    clear_i;
  logic [BCD_W*DIGITS-1:0] count_o;
  logic                    tick_o;
  logic                    wrap_o;
  logic                    stall_o;

  modport master (
    output enable_i, run_i, up_i, clear_i,
    input  count_o, tick_o, wrap_o, stall_o
  );

  modport slave (
    input  enable_i, run_i, up_i, clear_i,
    output count_o, tick_o, wrap_o, stall_o
  );

endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade of the up/down counter.
//   clk, rst_n  - clock, synchronous active-low reset
//   en          - advance this decade this cycle
//   up          - 1 = increment, 0 = decrement
//   clr         - synchronous clear, wins over en
//   value       - registered decade value (0..9)
//   carry_o     - decade sits at 9 while counting up (would carry if advanced)
//   borrow_o    - decade sits at 0 while counting down (would borrow if advanced)
module bcd_digit
  import tick_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic up,
  input  logic clr,
  output bcd_t value,
  output logic carry_o,
  output logic borrow_o
);

  // Limit flags depend only on the held value, so the enable chain has no loop.
  assign carry_o  = up & (value == BCD_MAX);
  assign borrow_o = ~up & (value == BCD_MIN);

  // Decade register: clear beats advance; wraps 9->0 up and 0->9 down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= BCD_MIN;
    end else if (clr) begin
      value <= BCD_MIN;
    end else if (en) begin
      if (up) value <= (value == BCD_MAX) ? BCD_MIN : value + 4'd1;
      else    value <= (value == BCD_MIN) ? BCD_MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/tick_counter.sv
// tick_counter: turns rising edges of a divided square-wave enable into one-cycle
// ticks and advances a DIGITS-wide BCD up/down counter; flags a stalled enable.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - tick_counter_if.slave (enable_i, run_i, up_i, clear_i in;
//                count_o, tick_o, wrap_o, stall_o out, all registered)
// Build option: TICK_SYNC_EN inserts a 2-flop synchronizer on enable_i
// (adds 2 cycles to every tick/count/stall latency).
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned STALL_CYCLES = 20000
)(
  input  logic           clk,
  input  logic           rst_n,
  tick_counter_if.slave  bus
);

  localparam int unsigned SW = $clog2(STALL_CYCLES + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

  logic en_s;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for an enable from another domain.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.enable_i};
  end

  assign en_s = sync_q[1];
`else
  assign en_s = bus.enable_i;
`endif

  state_t        state_q, state_d;
  logic          enable_q;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          rise_c, edge_c, tick_c, wrap_c;

  assign rise_c = en_s & ~enable_q;
  assign edge_c = en_s ^ enable_q;

  // State, edge history and stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      enable_q    <= en_s;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state, stall counter and tick qualification.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    tick_c      = 1'b0;

    if (edge_c || state_q == S_IDLE) stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX) stall_cnt_d = stall_cnt_q + SW'(1);

    unique case (state_q)
      S_IDLE:  if (bus.run_i) state_d = S_RUN;
      S_RUN: begin
        if (!bus.run_i)                     state_d = S_IDLE;
        else if (stall_cnt_d == STALL_MAX)  state_d = S_STALL;
      end
      S_STALL: begin
        if (!bus.run_i)  state_d = S_IDLE;
        else if (edge_c) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // A rising edge out of S_STALL is counted in the same cycle it resumes.
    tick_c = rise_c & bus.run_i & (state_q != S_IDLE);
  end

  bcd_t              digit  [DIGITS];
  logic [DIGITS-1:0] carry;
  logic [DIGITS-1:0] borrow;
  logic [DIGITS-1:0] dig_en;

  // Ripple enable: a decade advances when the tick reaches it through limit decades.
  always_comb begin
    dig_en    = '0;
    dig_en[0] = tick_c;
    for (int g = 1; g < int'(DIGITS); g++) begin
      dig_en[g] = dig_en[g-1] & (carry[g-1] | borrow[g-1]);
    end
    wrap_c = dig_en[DIGITS-1] & (carry[DIGITS-1] | borrow[DIGITS-1]) & ~bus.clear_i;
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (dig_en[g]),
      .up       (bus.up_i),
      .clr      (bus.clear_i),
      .value    (digit[g]),
      .carry_o  (carry[g]),
      .borrow_o (borrow[g])
    );
    assign bus.count_o[BCD_W*g +: BCD_W] = digit[g];
  end

  // Registered status pulses and stall level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.tick_o  <= 1'b0;
      bus.wrap_o  <= 1'b0;
      bus.stall_o <= 1'b0;
    end else begin
      bus.tick_o  <= tick_c;
      bus.wrap_o  <= wrap_c;
      bus.stall_o <= (state_d == S_STALL);
    end
  end

endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: scoreboard bench for tick_counter (DIGITS=2, STALL_CYCLES=8).
// Stimulus pushes the expected tick (cycle, count, wrap) into a queue; a negedge
// monitor pops and compares whenever tick_o is seen.
module tb_tick_counter;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned STALL  = 8;
`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] count;
    logic       wrap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_val  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tick_counter_if #(.DIGITS(DIGITS)) bus ();

  tick_counter #(.DIGITS(DIGITS), .STALL_CYCLES(STALL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: advance the decimal count and queue the expected tick.
  task automatic push_tick(input int at_cyc, input logic up, input logic clr);
    exp_t e;
    logic w;
    w = 1'b0;
    if (clr) begin
      exp_val = 0;
    end else if (up) begin
      w = (exp_val == 99);
      exp_val = (exp_val + 1) % 100;
    end else begin
      w = (exp_val == 0);
      exp_val = (exp_val + 99) % 100;
    end
    e.cyc = at_cyc; e.count = to_bcd(exp_val); e.wrap = w;
    exp_q.push_back(e);
  endtask

  task automatic pulse();
    bus.enable_i = 1'b1;
    push_tick(cyc + LAT, bus.up_i, 1'b0);
    step(2);
    bus.enable_i = 1'b0;
    step(2);
  endtask

  // Monitor: every tick must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.tick_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_tick: tick at cycle %0d count %0h, none expected", cyc, bus.count_o);
        end else begin
          e = exp_q.pop_front();
          check("tick_cycle", 32'(cyc), 32'(e.cyc));
          check("tick_count", 32'(bus.count_o), 32'(e.count));
          check("tick_wrap", 32'(bus.wrap_o), 32'(e.wrap));
        end
      end else if (bus.wrap_o !== 1'b0) begin
        check("wrap_without_tick", 32'(bus.wrap_o), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int c0;
    bus.enable_i = 1'b1;
    bus.run_i    = 1'b0;
    bus.up_i     = 1'b1;
    bus.clear_i  = 1'b0;
    rst_n        = 1'b0;
    step(3);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_tick",  32'(bus.tick_o),  32'd0);
    check("rst_wrap",  32'(bus.wrap_o),  32'd0);
    check("rst_stall", 32'(bus.stall_o), 32'd0);

    // Enable already high out of reset: no tick without a fresh rising edge.
    rst_n = 1'b1;
    step(5);
    check("idle_count", 32'(bus.count_o), 32'd0);
    bus.run_i = 1'b1;
    step(3);
    check("run_no_edge_count", 32'(bus.count_o), 32'd0);
    check("run_no_edge_stall", 32'(bus.stall_o), 32'd0);
    bus.enable_i = 1'b0;
    step(2);

    // Five rising edges counting up.
    repeat (5) pulse();
    check("count_5", 32'(bus.count_o), 32'h05);

    // Clear, then wrap downward and back upward.
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
    exp_val = 0;
    check("clear_count", 32'(bus.count_o), 32'h00);
    bus.up_i = 1'b0;
    pulse();
    check("down_wrap_count", 32'(bus.count_o), 32'h99);
    bus.up_i = 1'b1;
    pulse();
    check("up_wrap_count", 32'(bus.count_o), 32'h00);

    // Count to 42, then clear coincident with a tick.
    repeat (42) pulse();
    check("count_42", 32'(bus.count_o), 32'h42);
    c0 = cyc;
    bus.enable_i = 1'b1;
    if (LAT > 1) step(LAT - 1);
    bus.clear_i = 1'b1;
    push_tick(c0 + LAT, 1'b1, 1'b1);
    step(1);
    bus.clear_i = 1'b0;
    step(1);
    bus.enable_i = 1'b0;
    step(2);
    check("clear_tick_count", 32'(bus.count_o), 32'h00);

    // Stall: hold enable low after a falling edge for STALL cycles.
    bus.enable_i = 1'b1;
    push_tick(cyc + LAT, 1'b1, 1'b0);
    step(3);
    bus.enable_i = 1'b0;
    step(LAT + 7);
    check("stall_before", 32'(bus.stall_o), 32'd0);
    step(1);
    check("stall_asserted", 32'(bus.stall_o), 32'd1);
    step(5);
    check("stall_held", 32'(bus.stall_o), 32'd1);
    check("stall_count", 32'(bus.count_o), 32'h01);
    bus.enable_i = 1'b1;
    push_tick(cyc + LAT, 1'b1, 1'b0);
    step(LAT);
    check("stall_cleared", 32'(bus.stall_o), 32'd0);
    step(2);
    bus.enable_i = 1'b0;
    step(2);

    // run_i dropping in the cycle the edge is detected: not counted.
    bus.enable_i = 1'b1;
    if (LAT > 1) step(LAT - 1);
    bus.run_i = 1'b0;
    step(3);
    bus.enable_i = 1'b0;
    step(3);
    check("run_drop_count", 32'(bus.count_o), 32'(to_bcd(exp_val)));

    // Reset mid-operation with an edge pending.
    bus.run_i = 1'b1;
    step(1);
    pulse();
    pulse();
    check("pre_reset_count", 32'(bus.count_o), 32'h04);
    bus.enable_i = 1'b1;
    bus.run_i    = 1'b0;
    rst_n        = 1'b0;
    step(2);
    exp_val = 0;
    check("mid_rst_count", 32'(bus.count_o), 32'd0);
    check("mid_rst_tick",  32'(bus.tick_o),  32'd0);
    check("mid_rst_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;
    step(6);
    bus.run_i = 1'b1;
    step(2);
    check("post_rst_count", 32'(bus.count_o), 32'd0);
    bus.enable_i = 1'b0;
    step(2);
    pulse();
    check("post_rst_tick_count", 32'(bus.count_o), 32'h01);

    step(6);
    check("pending_ticks", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
